// File: rtl/data_memory.sv
// MEM-stage data memory: one word-addressed port, synchronous stores and
// registered read-first loads, every word cleared by a synchronous reset.
module data_memory #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH_MEM = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  m_clk,
  input  logic                  m_rst,
  input  logic                  m_i_ce,
  input  logic                  m_wr_en,
  input  logic                  m_rd_en,
  input  logic [AWIDTH_MEM-1:0] alu_value_addr,
  input  logic [DWIDTH-1:0]     m_i_store_data,
  output logic [DWIDTH-1:0]     m_o_load_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]     idx;

  assign idx = alu_value_addr[IW-1:0];

  // Upper address bits only alias the word index.
  generate
    if (AWIDTH_MEM > IW) begin : g_upper
      logic unused_upper_addr;
      assign unused_upper_addr = ^alu_value_addr[AWIDTH_MEM-1:IW];
    end
  endgenerate

  // Non-blocking update of mem gives read-first behaviour on a same-index RMW.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      m_o_load_data <= '0;
    end else if (m_i_ce) begin
      if (m_wr_en) mem[idx] <= m_i_store_data;
      if (m_rd_en) m_o_load_data <= mem[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: vector table plus reset sequences.
module tb_data_memory;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 1024;

  logic          m_clk = 1'b0;
  logic          m_rst = 1'b1;
  logic          m_i_ce = 1'b0;
  logic          m_wr_en = 1'b0;
  logic          m_rd_en = 1'b0;
  logic [AW-1:0] alu_value_addr = '0;
  logic [DW-1:0] m_i_store_data = '0;
  logic [DW-1:0] m_o_load_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          ce;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  data_memory #(.DWIDTH(DW), .AWIDTH_MEM(AW), .DEPTH(DEPTH)) dut (
    .m_clk(m_clk),
    .m_rst(m_rst),
    .m_i_ce(m_i_ce),
    .m_wr_en(m_wr_en),
    .m_rd_en(m_rd_en),
    .alu_value_addr(alu_value_addr),
    .m_i_store_data(m_i_store_data),
    .m_o_load_data(m_o_load_data)
  );

  always #5 m_clk = ~m_clk;

  function automatic void add(logic ce, logic wr, logic rd, logic [AW-1:0] addr,
                              logic [DW-1:0] wdata, logic [DW-1:0] exp, string name);
    vec_t v;
    v.ce = ce; v.wr = wr; v.rd = rd; v.addr = addr;
    v.wdata = wdata; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic rst, logic ce, logic wr, logic rd,
                       logic [AW-1:0] addr, logic [DW-1:0] wdata);
    m_rst = rst; m_i_ce = ce; m_wr_en = wr; m_rd_en = rd;
    alu_value_addr = addr; m_i_store_data = wdata;
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge m_clk);
    #1;
  endtask

  task automatic check(string name, logic [DW-1:0] exp);
    checks++;
    if (m_o_load_data !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, m_o_load_data, exp);
    end
  endtask

  initial begin
    // Store sweep: output stays at its post-reset 0 while only writing.
    for (int i = 0; i < 10; i++) add(1, 1, 0, i, i, 0, $sformatf("sweep_wr%0d", i));
    for (int i = 0; i < 10; i++) add(1, 0, 1, i, 0, i, $sformatf("sweep_rd%0d", i));
    add(0, 1, 0, 3, 32'hDEADBEEF, 9, "ce_off_wr_hold");
    add(1, 0, 1, 3, 0, 3, "ce_off_wr_blocked");
    add(0, 0, 1, 5, 0, 3, "ce_off_rd_hold");
    add(1, 0, 1, 7, 0, 7, "rd_addr7");
    add(1, 0, 0, 2, 0, 7, "rd_dis_hold");
    add(1, 1, 1, 4, 32'h55, 4, "rdw_old");
    add(1, 0, 1, 4, 0, 32'h55, "rdw_new");
    add(1, 0, 1, DEPTH + 1, 0, 1, "alias_rd");
    add(1, 1, 0, DEPTH + 6, 32'hA6, 1, "alias_wr");
    add(1, 0, 1, 6, 0, 32'hA6, "alias_wr_rd");
    add(1, 1, 1, 9, 32'h1234, 9, "rdw_old9");
    add(1, 0, 1, 9, 0, 32'h1234, "rdw_new9");

    // Reset held for two edges.
    drive(1, 1, 1, 1, 5, 32'hFFFF_FFFF);
    tick();
    tick();
    check("reset_out", 0);
    drive(0, 1, 0, 1, 5, 0);
    tick();
    check("reset_rd5", 0);

    foreach (vecs[k]) begin
      drive(0, vecs[k].ce, vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wdata);
      tick();
      check(vecs[k].name, vecs[k].exp);
    end

    // Mid-run reset with a store pending to addr 8.
    drive(0, 1, 0, 1, 8, 0);
    tick();
    check("pre_rst_rd8", 8);
    drive(1, 1, 1, 0, 8, 32'h99);
    tick();
    check("midrst_out", 0);
    drive(0, 1, 0, 1, 8, 0);
    tick();
    check("midrst_rd8", 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 1, i, 0);
      tick();
      check($sformatf("midrst_rd%0d", i), 0);
    end
    // Prove the array is usable after reset (output not stuck at 0).
    drive(0, 1, 1, 0, 2, 32'hCAFE);
    tick();
    drive(0, 1, 0, 1, 2, 0);
    tick();
    check("post_rst_wr_rd", 32'hCAFE);

    drive(0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
